// File: rtl/vu_pkg.sv
// -----------------------------------------------------------------------------
// vu_pkg
// Shared definitions for the VU-meter level display:
//   - GRB colour constants for the three bar zones and the off pixel
//   - default WS2812 bit / latch timing in system clock cycles
//   - state enums for the UART receiver and the pixel serializer
// -----------------------------------------------------------------------------
package vu_pkg;

    // Colours are packed GRB, most significant byte first on the wire.
    localparam logic [23:0] COL_GREEN  = 24'h100000;
    localparam logic [23:0] COL_YELLOW = 24'h101000;
    localparam logic [23:0] COL_RED    = 24'h001000;
    localparam logic [23:0] COL_OFF    = 24'h000000;

    // WS2812 timing at a 50 MHz clock.
    localparam int WS_T0H    = 20;
    localparam int WS_T1H    = 40;
    localparam int WS_TBIT   = 63;
    localparam int WS_TRESET = 2600;

    localparam int BITS_PER_PIXEL = 24;

    typedef enum logic [1:0] {
        UART_IDLE,
        UART_START,
        UART_DATA,
        UART_STOP
    } uart_state_t;

    typedef enum logic [1:0] {
        DRV_IDLE,
        DRV_BIT_HIGH,
        DRV_BIT_LOW,
        DRV_LATCH
    } drv_state_t;

endpackage

// File: rtl/uart_rx_8n1.sv
// -----------------------------------------------------------------------------
// uart_rx_8n1
// 8N1 UART receiver, LSB first, with a two-flop synchroniser on the line.
// Ports:
//   i_clk    system clock
//   i_rst    synchronous active-high reset
//   i_rx     asynchronous serial line, idle high
//   o_data   last correctly framed byte
//   o_valid  one-cycle strobe when o_data carries a new byte
// -----------------------------------------------------------------------------
module uart_rx_8n1
    import vu_pkg::*;
#(
    parameter int CLKS_PER_BIT = 416
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_rx,
    output logic [7:0] o_data,
    output logic       o_valid
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    logic          rx_meta;
    logic          rx_sync;
    uart_state_t   state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;

    // NOTE: sequential state is always assigned with <= so every flop samples
    // the pre-edge values; mixing in = here would create ordering-dependent logic.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            state   <= UART_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            o_data  <= '0;
            o_valid <= 1'b0;
        end else begin
            rx_meta <= i_rx;
            rx_sync <= rx_meta;
            o_valid <= 1'b0;

            case (state)
                UART_IDLE: begin
                    cnt <= '0;
                    if (!rx_sync) state <= UART_START;
                end

                // Re-check the line half a bit in; a short low pulse is a glitch.
                UART_START: begin
                    if (cnt == HALF_LAST) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= rx_sync ? UART_IDLE : UART_DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                UART_DATA: begin
                    if (cnt == FULL_LAST) begin
                        cnt   <= '0;
                        shreg <= {rx_sync, shreg[7:1]};
                        if (bit_idx == 3'd7) state <= UART_STOP;
                        else                 bit_idx <= bit_idx + 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                // A low stop bit is a framing error: the byte is dropped.
                UART_STOP: begin
                    if (cnt == FULL_LAST) begin
                        cnt   <= '0;
                        state <= UART_IDLE;
                        if (rx_sync) begin
                            o_data  <= shreg;
                            o_valid <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                default: state <= UART_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/vu_level_display.sv
// -----------------------------------------------------------------------------
// vu_level_display
// Receives a level byte over UART and renders it as a bar graph on a WS2812
// chain: pixels 0..level-1 lit in green/yellow/red zones, the rest off.
// Ports:
//   i_clk        system clock (50 MHz nominal)
//   i_rst        synchronous active-high reset
//   i_rx         UART receive line, idle high
//   o_npxl_data  WS2812 one-wire data
//   o_rdy        high when no frame is being sent and none is pending
// -----------------------------------------------------------------------------
module vu_level_display
    import vu_pkg::*;
#(
    parameter int CLKS_PER_BIT = 416,
    parameter int NUM_LEDS     = 20,
    parameter int GREEN_N      = 12,
    parameter int YELLOW_N     = 5,
    parameter int T0H          = WS_T0H,
    parameter int T1H          = WS_T1H,
    parameter int TBIT         = WS_TBIT,
    parameter int TRESET       = WS_TRESET
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_rx,
    output logic o_npxl_data,
    output logic o_rdy
);

    localparam int LW = $clog2(NUM_LEDS + 1);
    localparam int PW = $clog2(NUM_LEDS);
    localparam int BW = $clog2(BITS_PER_PIXEL);
    localparam int TW = $clog2((TRESET > TBIT) ? TRESET : TBIT);

    localparam logic [PW-1:0] LAST_PIX    = PW'(NUM_LEDS - 1);
    localparam logic [BW-1:0] LAST_BIT    = BW'(BITS_PER_PIXEL - 1);
    localparam logic [BW-1:0] SECOND_BIT  = BW'(BITS_PER_PIXEL - 2);
    localparam logic [TW-1:0] T0H_LAST    = TW'(T0H - 1);
    localparam logic [TW-1:0] T1H_LAST    = TW'(T1H - 1);
    localparam logic [TW-1:0] TBIT_LAST   = TW'(TBIT - 1);
    localparam logic [TW-1:0] TRESET_LAST = TW'(TRESET - 1);

    // Zone colour of pixel idx for a bar of height lvl.
    function automatic logic [23:0] colour_of(input int idx, input int lvl);
        if (idx >= lvl)                  return COL_OFF;
        else if (idx < GREEN_N)          return COL_GREEN;
        else if (idx < GREEN_N + YELLOW_N) return COL_YELLOW;
        else                             return COL_RED;
    endfunction

    logic [7:0]    rx_byte;
    logic          rx_valid;

    logic [LW-1:0] level;
    logic [LW-1:0] frame_level;
    logic          pending;

    drv_state_t    state;
    logic [PW-1:0] pix;
    logic [BW-1:0] bit_idx;
    logic [TW-1:0] tcnt;
    logic          bit_one;

    logic [23:0]   next_col;
    logic          next_one;
    logic [23:0]   first_col;
    logic          launch;

    uart_rx_8n1 #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_rx   (i_rx),
        .o_data (rx_byte),
        .o_valid(rx_valid)
    );

    // Value of the bit that follows the one currently on the wire, and the
    // first bit of a frame about to be launched from the pending level.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        next_col = COL_OFF;
        next_one = 1'b0;
        if (bit_idx == LAST_BIT) begin
            next_col = colour_of(int'(pix) + 1, int'(frame_level));
            next_one = next_col[23];
        end else begin
            next_col = colour_of(int'(pix), int'(frame_level));
            next_one = next_col[SECOND_BIT - bit_idx];
        end

        first_col = colour_of(0, int'(level));

        // A frame starts from idle, or straight out of the latch gap.
        launch = pending &&
                 ((state == DRV_IDLE) ||
                  (state == DRV_LATCH && tcnt == TRESET_LAST));
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= DRV_IDLE;
            o_npxl_data <= 1'b0;
            o_rdy       <= 1'b1;
            level       <= '0;
            frame_level <= '0;
            pending     <= 1'b0;
            pix         <= '0;
            bit_idx     <= '0;
            tcnt        <= '0;
            bit_one     <= 1'b0;
        end else begin
            case (state)
                DRV_IDLE: ;

                DRV_BIT_HIGH: begin
                    if (tcnt == (bit_one ? T1H_LAST : T0H_LAST)) begin
                        o_npxl_data <= 1'b0;
                        state       <= DRV_BIT_LOW;
                    end
                    tcnt <= tcnt + 1'b1;
                end

                // The bit period runs on from the high phase; the next bit
                // starts with no gap, across pixel boundaries too.
                DRV_BIT_LOW: begin
                    if (tcnt == TBIT_LAST) begin
                        tcnt <= '0;
                        if (bit_idx == LAST_BIT && pix == LAST_PIX) begin
                            state <= DRV_LATCH;
                        end else begin
                            o_npxl_data <= 1'b1;
                            bit_one     <= next_one;
                            state       <= DRV_BIT_HIGH;
                            if (bit_idx == LAST_BIT) begin
                                bit_idx <= '0;
                                pix     <= pix + 1'b1;
                            end else begin
                                bit_idx <= bit_idx + 1'b1;
                            end
                        end
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end

                DRV_LATCH: begin
                    if (tcnt == TRESET_LAST) begin
                        tcnt <= '0;
                        if (!pending) begin
                            state <= DRV_IDLE;
                            o_rdy <= 1'b1;
                        end
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end

                default: state <= DRV_IDLE;
            endcase

            if (launch) begin
                pending     <= 1'b0;
                frame_level <= level;
                pix         <= '0;
                bit_idx     <= '0;
                tcnt        <= '0;
                bit_one     <= first_col[23];
                o_npxl_data <= 1'b1;
                o_rdy       <= 1'b0;
                state       <= DRV_BIT_HIGH;
            end

            // Placed after the launch so a byte landing on the launch cycle
            // stays pending for the following frame.
            if (rx_valid) begin
                level   <= (int'(rx_byte) > NUM_LEDS) ? LW'(NUM_LEDS) : LW'(rx_byte);
                pending <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_vu_level_display.sv
// -----------------------------------------------------------------------------
// tb_vu_level_display
// Drives UART bytes into vu_level_display, decodes the WS2812 waveform back
// into pixel colours and compares against a bar-graph model of the display.
// Timing parameters are scaled down so whole frames stay short.
// -----------------------------------------------------------------------------
module tb_vu_level_display;

    localparam int CPB      = 16;
    localparam int NUM_LEDS = 20;
    localparam int GREEN_N  = 12;
    localparam int YELLOW_N = 5;
    localparam int T0H      = 2;
    localparam int T1H      = 5;
    localparam int TBIT     = 8;
    localparam int TRESET   = 64;
    localparam int NBITS    = NUM_LEDS * 24;
    localparam int FRAME    = NBITS * TBIT + TRESET;
    localparam int WAIT_LIM = 20 * CPB + TRESET + 100;

    logic clk = 1'b0;
    logic i_rst;
    logic i_rx;
    logic o_npxl_data;
    logic o_rdy;

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int stop_begin_cyc = 0;
    int frame_start_cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    vu_level_display #(
        .CLKS_PER_BIT(CPB),
        .NUM_LEDS    (NUM_LEDS),
        .GREEN_N     (GREEN_N),
        .YELLOW_N    (YELLOW_N),
        .T0H         (T0H),
        .T1H         (T1H),
        .TBIT        (TBIT),
        .TRESET      (TRESET)
    ) dut (
        .i_clk      (clk),
        .i_rst      (i_rst),
        .i_rx       (i_rx),
        .o_npxl_data(o_npxl_data),
        .o_rdy      (o_rdy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Bar-graph model: the displayed height is the byte clamped to the strip
    // length, and each lit pixel takes the colour of the zone it sits in.
    function automatic logic [23:0] model_pixel(input int i, input int byte_val);
        int height;
        height = (byte_val > NUM_LEDS) ? NUM_LEDS : byte_val;
        if (i >= height)                return 24'h000000;
        if (i < GREEN_N)                return 24'h100000;
        if (i < GREEN_N + YELLOW_N)     return 24'h101000;
        return 24'h001000;
    endfunction

    task automatic send_byte(input logic [7:0] b, input bit good_stop);
        @(negedge clk);
        i_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            i_rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        stop_begin_cyc = cyc;
        i_rx = good_stop;
        repeat (CPB) @(negedge clk);
        i_rx = 1'b1;
    endtask

    // Decodes one whole frame, sampling on falling edges. Leaves the caller on
    // the sample where the line rose again or o_rdy returned high.
    task automatic capture_frame(input int byte_val, input bit idle_after, input string tag);
        logic [23:0] got [NUM_LEDS];
        int waited, h, l, lim, bad, last_low;
        bit bv;
        waited = 0;
        while (o_npxl_data !== 1'b1 && waited < WAIT_LIM) begin
            @(negedge clk);
            waited++;
        end
        check({tag, "_frame_start"}, o_npxl_data, 1'b1);
        if (o_npxl_data !== 1'b1) return;
        check({tag, "_rdy_low_first_bit"}, o_rdy, 1'b0);
        frame_start_cyc = cyc;
        bad = 0;
        last_low = 0;
        for (int k = 0; k < NBITS; k++) begin
            h = 0;
            while (o_npxl_data === 1'b1 && h <= TBIT) begin
                h++;
                @(negedge clk);
            end
            l = 0;
            lim = (k == NBITS - 1) ? TBIT + TRESET + 4 : TBIT;
            while (o_npxl_data === 1'b0 && o_rdy !== 1'b1 && l <= lim) begin
                l++;
                @(negedge clk);
            end
            bv = (h == T1H);
            if (h != T0H && h != T1H) bad++;
            if (k != NBITS - 1 && h + l != TBIT) bad++;
            if (k == NBITS - 1) last_low = l;
            got[k / 24][23 - (k % 24)] = bv;
        end
        check({tag, "_bit_timing_errors"}, bad, 0);
        // Final colour bit is always 0, so its low tail plus the latch gap.
        check({tag, "_latch_low"}, last_low, TBIT - T0H + TRESET);
        for (int i = 0; i < NUM_LEDS; i++)
            check($sformatf("%s_pix%0d", tag, i), got[i], model_pixel(i, byte_val));
        check({tag, "_rdy_after"}, o_rdy, idle_after);
    endtask

    task automatic send_and_capture(input logic [7:0] b, input string tag);
        int lat;
        fork
            send_byte(b, 1'b1);
            capture_frame(int'(b), 1'b1, tag);
        join
        lat = frame_start_cyc - stop_begin_cyc;
        check({tag, "_start_latency_in_stop_bit"}, (lat >= CPB / 2 && lat < CPB), 1'b1);
        repeat (20) @(negedge clk);
    endtask

    task automatic expect_quiet(input int n, input string tag);
        int highs;
        highs = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (o_npxl_data !== 1'b0) highs++;
        end
        check({tag, "_no_pulse"}, highs, 0);
        check({tag, "_rdy"}, o_rdy, 1'b1);
    endtask

    initial begin
        logic [7:0] rb;
        int waited;

        // Reset state and silence afterwards.
        i_rst = 1'b1;
        i_rx  = 1'b1;
        repeat (4) @(negedge clk);
        check("reset_data", o_npxl_data, 1'b0);
        check("reset_rdy", o_rdy, 1'b1);
        i_rst = 1'b0;
        expect_quiet(300, "after_reset");

        // Directed levels including zero and a clamped value.
        send_and_capture(8'd3,  "lvl3");
        send_and_capture(8'd11, "lvl11");
        send_and_capture(8'd20, "lvl20");
        send_and_capture(8'd0,  "lvl0");
        send_and_capture(8'd25, "lvl25");

        // Random levels: one within range, two over the whole byte range.
        for (int r = 0; r < 3; r++) begin
            rb = (r == 0) ? 8'($urandom_range(0, NUM_LEDS)) : 8'($urandom_range(0, 255));
            send_and_capture(rb, $sformatf("rand%0d_%0d", r, rb));
        end

        // Framing error and a short line glitch produce nothing.
        send_byte(8'd7, 1'b0);
        expect_quiet(400, "framing_error");
        @(negedge clk);
        i_rx = 1'b0;
        repeat (CPB / 4) @(negedge clk);
        i_rx = 1'b1;
        expect_quiet(400, "glitch");

        // Two bytes during a level-20 frame: it completes, then the last wins.
        fork
            begin
                capture_frame(20, 1'b0, "mid_first");
                capture_frame(5, 1'b1, "mid_second");
            end
            begin
                send_byte(8'd20, 1'b1);
                waited = 0;
                while (o_npxl_data !== 1'b1 && waited < WAIT_LIM) begin
                    @(negedge clk);
                    waited++;
                end
                repeat (300) @(negedge clk);
                send_byte(8'd2, 1'b1);
                send_byte(8'd5, 1'b1);
            end
        join
        repeat (20) @(negedge clk);

        // Reset in the middle of a frame aborts it at once.
        send_byte(8'd15, 1'b1);
        waited = 0;
        while (o_npxl_data !== 1'b1 && waited < WAIT_LIM) begin
            @(negedge clk);
            waited++;
        end
        check("midreset_frame_started", o_npxl_data, 1'b1);
        repeat (1000) @(negedge clk);
        i_rst = 1'b1;
        @(negedge clk);
        check("midreset_data", o_npxl_data, 1'b0);
        check("midreset_rdy", o_rdy, 1'b1);
        i_rst = 1'b0;
        expect_quiet(FRAME + 100, "after_midreset");

        // Recovers normally on the next byte.
        send_and_capture(8'd4, "recover4");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
